// File: rtl/mem_bus_arbiter_pkg.sv
// Shared address map, bus payload types and helpers for the memory bus arbiter.
package mem_bus_arbiter_pkg;

  localparam int unsigned ADDR_W  = 32;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned STRB_W  = 4;
  localparam int unsigned NUM_SLV = 4;

  localparam logic [ADDR_W-1:0] BRAM_BASE_ADDR  = 32'h0000_0000;
  localparam logic [ADDR_W-1:0] BRAM_TOP_ADDR   = 32'h0010_0000;
  localparam logic [ADDR_W-1:0] PRINT_BASE_ADDR = 32'h0100_0000;
  localparam logic [ADDR_W-1:0] PRINT_TOP_ADDR  = 32'h0100_0004;
  localparam logic [ADDR_W-1:0] CLINT_BASE_ADDR = 32'h0200_0000;
  localparam logic [ADDR_W-1:0] CLINT_TOP_ADDR  = 32'h0200_C000;
  localparam logic [ADDR_W-1:0] CLIC_BASE_ADDR  = 32'h0300_0000;
  localparam logic [ADDR_W-1:0] CLIC_TOP_ADDR   = 32'h0300_5000;

  typedef enum logic [1:0] {SLV_BRAM, SLV_PRINT, SLV_CLINT, SLV_CLIC} slv_idx_e;
  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_RESP} arb_state_e;
  typedef enum logic {GNT_IMEM, GNT_DMEM} gnt_e;

  typedef struct packed {
    logic              valid;
    logic              instr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] wstrb;
  } mem_req_t;

  typedef struct packed {
    logic [DATA_W-1:0] rdata;
    logic              ready;
    logic              error;
  } mem_rsp_t;

  // Half-open unsigned region test: base <= addr < top.
  function automatic logic in_region(input logic [ADDR_W-1:0] addr,
                                     input logic [ADDR_W-1:0] base,
                                     input logic [ADDR_W-1:0] top);
    return (addr >= base) && (addr < top);
  endfunction

endpackage

// File: rtl/mem_bus_arbiter_addr_decoder.sv
// Combinational address decode into a one-hot slave select plus a miss flag.
module mem_bus_arbiter_addr_decoder
  import mem_bus_arbiter_pkg::*;
#(
  parameter logic [ADDR_W-1:0] bram_base_addr  = BRAM_BASE_ADDR,
  parameter logic [ADDR_W-1:0] bram_top_addr   = BRAM_TOP_ADDR,
  parameter logic [ADDR_W-1:0] print_base_addr = PRINT_BASE_ADDR,
  parameter logic [ADDR_W-1:0] print_top_addr  = PRINT_TOP_ADDR,
  parameter logic [ADDR_W-1:0] clint_base_addr = CLINT_BASE_ADDR,
  parameter logic [ADDR_W-1:0] clint_top_addr  = CLINT_TOP_ADDR,
  parameter logic [ADDR_W-1:0] clic_base_addr  = CLIC_BASE_ADDR,
  parameter logic [ADDR_W-1:0] clic_top_addr   = CLIC_TOP_ADDR
) (
  input  logic [ADDR_W-1:0]  addr,
  output logic [NUM_SLV-1:0] sel_c,
  output logic               miss_c
);

  // One bit per region; regions never overlap so at most one bit is set.
  always_comb begin
    sel_c            = '0;
    sel_c[SLV_BRAM]  = in_region(addr, bram_base_addr,  bram_top_addr);
    sel_c[SLV_PRINT] = in_region(addr, print_base_addr, print_top_addr);
    sel_c[SLV_CLINT] = in_region(addr, clint_base_addr, clint_top_addr);
    sel_c[SLV_CLIC]  = in_region(addr, clic_base_addr,  clic_top_addr);
    miss_c           = ~|sel_c;
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing one slave bus between the fetch and data ports.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter logic [ADDR_W-1:0] bram_base_addr  = BRAM_BASE_ADDR,
  parameter logic [ADDR_W-1:0] bram_top_addr   = BRAM_TOP_ADDR,
  parameter logic [ADDR_W-1:0] print_base_addr = PRINT_BASE_ADDR,
  parameter logic [ADDR_W-1:0] print_top_addr  = PRINT_TOP_ADDR,
  parameter logic [ADDR_W-1:0] clint_base_addr = CLINT_BASE_ADDR,
  parameter logic [ADDR_W-1:0] clint_top_addr  = CLINT_TOP_ADDR,
  parameter logic [ADDR_W-1:0] clic_base_addr  = CLIC_BASE_ADDR,
  parameter logic [ADDR_W-1:0] clic_top_addr   = CLIC_TOP_ADDR
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            imem_valid,
  input  logic [ADDR_W-1:0]               imem_addr,
  output logic [DATA_W-1:0]               imem_rdata,
  output logic                            imem_ready,
  output logic                            imem_error,
  input  logic                            dmem_valid,
  input  logic                            dmem_instr,
  input  logic [ADDR_W-1:0]               dmem_addr,
  input  logic [DATA_W-1:0]               dmem_wdata,
  input  logic [STRB_W-1:0]               dmem_wstrb,
  output logic [DATA_W-1:0]               dmem_rdata,
  output logic                            dmem_ready,
  output logic                            dmem_error,
  output logic                            bus_instr,
  output logic [ADDR_W-1:0]               bus_addr,
  output logic [DATA_W-1:0]               bus_wdata,
  output logic [STRB_W-1:0]               bus_wstrb,
  output logic [NUM_SLV-1:0]              bus_sel,
  input  logic [NUM_SLV-1:0][DATA_W-1:0]  slv_rdata,
  input  logic [NUM_SLV-1:0]              slv_ready
);

  arb_state_e          state_q, state_d;
  gnt_e                last_gnt_q, last_gnt_d;
  logic                bus_instr_q, bus_instr_d;
  logic [ADDR_W-1:0]   bus_addr_q, bus_addr_d;
  logic [DATA_W-1:0]   bus_wdata_q, bus_wdata_d;
  logic [STRB_W-1:0]   bus_wstrb_q, bus_wstrb_d;
  logic [NUM_SLV-1:0]  bus_sel_q, bus_sel_d;
  mem_rsp_t            imem_rsp_q, imem_rsp_d;
  mem_rsp_t            dmem_rsp_q, dmem_rsp_d;

  logic                win_dmem_c;
  mem_req_t            win_req_c;
  logic [NUM_SLV-1:0]  dec_sel_c;
  logic                dec_miss_c;
  logic [DATA_W-1:0]   sel_rdata_c;

  // Winner selection: on a tie, grant the master that was not granted last.
  always_comb begin
    win_dmem_c = dmem_valid & (~imem_valid | (last_gnt_q == GNT_IMEM));
    if (win_dmem_c) begin
      win_req_c = '{valid: 1'b1, instr: dmem_instr, addr: dmem_addr,
                    wdata: dmem_wdata, wstrb: dmem_wstrb};
    end else begin
      win_req_c = '{valid: imem_valid, instr: 1'b1, addr: imem_addr,
                    wdata: '0, wstrb: '0};
    end
  end

  mem_bus_arbiter_addr_decoder #(
    .bram_base_addr  (bram_base_addr),
    .bram_top_addr   (bram_top_addr),
    .print_base_addr (print_base_addr),
    .print_top_addr  (print_top_addr),
    .clint_base_addr (clint_base_addr),
    .clint_top_addr  (clint_top_addr),
    .clic_base_addr  (clic_base_addr),
    .clic_top_addr   (clic_top_addr)
  ) u_addr_decoder (
    .addr   (win_req_c.addr),
    .sel_c  (dec_sel_c),
    .miss_c (dec_miss_c)
  );

  // Read data from the currently selected slave only.
  always_comb begin
    sel_rdata_c = '0;
    for (int i = 0; i < NUM_SLV; i++) begin
      if (bus_sel_q[i]) sel_rdata_c = sel_rdata_c | slv_rdata[i];
    end
  end

  // Next-state and registered-output logic; responses default to a 1-cycle pulse.
  always_comb begin
    state_d     = state_q;
    last_gnt_d  = last_gnt_q;
    bus_instr_d = bus_instr_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    bus_wstrb_d = bus_wstrb_q;
    bus_sel_d   = '0;
    imem_rsp_d  = '0;
    dmem_rsp_d  = '0;
    case (state_q)
      ST_IDLE: begin
        if (win_req_c.valid) begin
          last_gnt_d  = win_dmem_c ? GNT_DMEM : GNT_IMEM;
          bus_instr_d = win_req_c.instr;
          bus_addr_d  = win_req_c.addr;
          bus_wdata_d = win_req_c.wdata;
          bus_wstrb_d = win_req_c.wstrb;
          if (dec_miss_c) begin
            state_d = ST_RESP;
            if (win_dmem_c) dmem_rsp_d = '{rdata: '0, ready: 1'b1, error: 1'b1};
            else            imem_rsp_d = '{rdata: '0, ready: 1'b1, error: 1'b1};
          end else begin
            state_d   = ST_REQ;
            bus_sel_d = dec_sel_c;
          end
        end
      end
      ST_REQ: begin
        bus_sel_d = bus_sel_q;
        if (|(slv_ready & bus_sel_q)) begin
          state_d   = ST_RESP;
          bus_sel_d = '0;
          if (last_gnt_q == GNT_DMEM) dmem_rsp_d = '{rdata: sel_rdata_c, ready: 1'b1, error: 1'b0};
          else                        imem_rsp_d = '{rdata: sel_rdata_c, ready: 1'b1, error: 1'b0};
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      last_gnt_q  <= GNT_IMEM;
      bus_instr_q <= 1'b0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      bus_wstrb_q <= '0;
      bus_sel_q   <= '0;
      imem_rsp_q  <= '0;
      dmem_rsp_q  <= '0;
    end else begin
      state_q     <= state_d;
      last_gnt_q  <= last_gnt_d;
      bus_instr_q <= bus_instr_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      bus_wstrb_q <= bus_wstrb_d;
      bus_sel_q   <= bus_sel_d;
      imem_rsp_q  <= imem_rsp_d;
      dmem_rsp_q  <= dmem_rsp_d;
    end
  end

  assign bus_instr  = bus_instr_q;
  assign bus_addr   = bus_addr_q;
  assign bus_wdata  = bus_wdata_q;
  assign bus_wstrb  = bus_wstrb_q;
  assign bus_sel    = bus_sel_q;
  assign imem_rdata = imem_rsp_q.rdata;
  assign imem_ready = imem_rsp_q.ready;
  assign imem_error = imem_rsp_q.error;
  assign dmem_rdata = dmem_rsp_q.rdata;
  assign dmem_ready = dmem_rsp_q.ready;
  assign dmem_error = dmem_rsp_q.error;

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares one downstream memory/peripheral bus between the core's instruction-fetch port (imem) and data port (dmem).
- Decodes each granted request into one of four slaves: bram, print, clint, clic.
- Unmapped addresses get an error response.
- Sits between the core and the slave blocks in the SoC top level.
- Address map parameters default to the values held in the shared configure package.

Parameters:
- bram_base_addr, 32'h000000, bram region start (inclusive)
- bram_top_addr, 32'h100000, bram region end (exclusive)
- print_base_addr, 32'h1000000, print region start
- print_top_addr, 32'h1000004, print region end
- clint_base_addr, 32'h2000000, clint region start
- clint_top_addr, 32'h200C000, clint region end
- clic_base_addr, 32'h3000000, clic region start
- clic_top_addr, 32'h3005000, clic region end

Ports:
- clock  in  1  single system clock, rising edge
- reset  in  1  synchronous, active-high reset
- imem_valid  in  1  fetch request; held high until imem_ready
- imem_addr  in  32  fetch byte address
- imem_rdata  out  32  fetch read data
- imem_ready  out  1  one-cycle completion pulse
- imem_error  out  1  qualifies imem_ready: address unmapped
- dmem_valid  in  1  data request; held high until dmem_ready
- dmem_instr  in  1  request is an instruction access, passed downstream
- dmem_addr  in  32  data byte address
- dmem_wdata  in  32  write data
- dmem_wstrb  in  4  byte strobes; 0 = read
- dmem_rdata  out  32  read data
- dmem_ready  out  1  one-cycle completion pulse
- dmem_error  out  1  qualifies dmem_ready: address unmapped
- bus_instr  out  1  latched instr flag (1 for imem grants)
- bus_addr  out  32  latched address
- bus_wdata  out  32  latched write data
- bus_wstrb  out  4  latched strobes (0 for imem grants)
- bus_sel  out  4  one-hot slave valid: [0] bram, [1] print, [2] clint, [3] clic
- slv_rdata  in  4x32  per-slave read data
- slv_ready  in  4  per-slave completion

Behaviour:
- Reset: state IDLE, last_grant = IMEM (so dmem wins the first tie). All outputs 0: bus_sel, bus_* and both ready/error/rdata.
- FSM states: IDLE, REQ, RESP.

IDLE:
- On any valid, grant one master.
- If both are valid, round-robin: grant the master not granted last.
- Latch addr/wdata/wstrb/instr of the winner and record grant and last_grant.
- Register the one-hot decode: region hit when base <= addr < top, unsigned 32-bit compare.
- No region hit: go to RESP with error=1, rdata=0.
- Region hit: go to REQ.
- A request is accepted no earlier than the cycle it appears, so bus_sel first rises 1 cycle after the master valid is sampled.

REQ:
- bus_sel = latched one-hot; bus_* held stable.
- Wait for slv_ready[sel]; ignore ready bits of unselected slaves.
- On ready: latch slv_rdata[sel], drop bus_sel the next cycle, go to RESP.
- There is no timeout; a slave that never responds stalls the bus indefinitely.

RESP:
- Pulse the granted master's ready for exactly 1 cycle, with rdata and error valid that cycle. Return to IDLE.
- The other master's ready, error and rdata stay 0.

Latency and throughput:
- Best-case latency, zero-wait slave: valid sampled at cycle N, bus_sel at N+1, slave ready at N+1, master ready at N+2.
- Unmapped address: ready at N+1.
- Back-to-back: IDLE re-arbitrates the cycle after RESP, so a pending master waits 1 idle cycle.
- Masters are required to keep valid and request fields stable until ready. The arbiter uses only the latched copy.

Other rules:
- A valid that drops before acceptance is simply not granted.
- Writes to read-only regions are forwarded unchanged; slaves decide.
- Reset mid-transaction: return to IDLE next edge, bus_sel = 0, no ready pulse. Slaves must tolerate an abandoned request.

Decomposition:
- Shared package (configure): the address-map constants above, plus typedefs:
  - mem_req_t {valid, instr, addr, wdata, wstrb}
  - mem_rsp_t {rdata, ready, error}
  - slave index enum {SLV_BRAM, SLV_PRINT, SLV_CLINT, SLV_CLIC}
- Natural sub-module: addr_decoder. Purely combinational: addr -> 4-bit one-hot + miss bit. Reused by the core's PMA checks.

Test Plan:
1. dmem read from 32'h00000010 with a zero-wait bram returning 32'hDEADBEEF -> bus_sel=4'b0001 at N+1; dmem_ready, rdata=DEADBEEF, error=0 at N+2.
2. imem and dmem both valid after reset -> dmem granted first. imem granted next in IDLE, with bus_instr=1 and wstrb=0. Repeat 4 times and check strict alternation.
3. dmem write to 32'h1000000, wdata=0x41, wstrb=4'b0001, print ready after 3 wait cycles -> bus_sel=4'b0010 held 4 cycles, bus fields stable, dmem_ready 1 cycle after slave ready.
4. Boundary addresses 32'h0FFFFC (bram), 32'h100000 (miss), 32'h200BFFC (clint), 32'h3005000 (miss) -> correct one-hot, or error=1 with rdata=0 at N+1 and bus_sel never raised.
5. Reset asserted while in REQ with a clic slave stalling -> next cycle bus_sel=0 and no master ready pulse. A fresh request after reset gets dmem priority.
6. A slave ready on an unselected slave during REQ -> ignored; the transaction completes only on the selected ready.
